// File: rtl/fire5_ex_3_ifm_streamer.sv
// Captures the fire5 squeeze map and replays it as 3x3xCHIN windows for the expand MAC array.
// Define FIRE5_EX_3_ZERO_PAD_EN to honour PAD and emit zero border taps.
module fire5_ex_3_ifm_streamer #(
  parameter int WIDTH      = 16,
  parameter int W_IN       = 32,
  parameter int H_IN       = 32,
  parameter int CHIN       = 32,
  parameter int KERNEL_DIM = 3,
  parameter int STRIDE     = 1,
  parameter int PAD        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             loaded,
  input  logic             start,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] pix,
  output logic             pix_valid,
  output logic             win_last,
  output logic             busy,
  output logic             done
);

`ifdef FIRE5_EX_3_ZERO_PAD_EN
  localparam int PAD_E = PAD;
`else
  localparam int PAD_E = PAD * 0;
`endif
  localparam int DEPTH = W_IN * H_IN * CHIN;
  localparam int W_OUT = (W_IN + 2 * PAD_E - KERNEL_DIM) / STRIDE + 1;
  localparam int H_OUT = (H_IN + 2 * PAD_E - KERNEL_DIM) / STRIDE + 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int KW    = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int OXW   = (W_OUT > 1) ? $clog2(W_OUT) : 1;
  localparam int OYW   = (H_OUT > 1) ? $clog2(H_OUT) : 1;
`ifdef FIRE5_EX_3_ZERO_PAD_EN
  localparam int IW    = AW + 2;
`else
  localparam int IW    = AW;
`endif

  typedef enum logic [2:0] {LOAD, READY, STREAM, GAP, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    waddr_q;
  logic [CW-1:0]    ch_q;
  logic [KW-1:0]    kx_q, ky_q;
  logic [OXW-1:0]   ox_q;
  logic [OYW-1:0]   oy_q;

  logic             v1_q, wl1_q, pv_q, wl_q;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] pix_q;
  logic [IW-1:0]    ix, iy;

  logic wr_fire, wr_last, last_tap, last_win, adv, drained;

  assign wr_fire  = (state_q == LOAD) && wr_valid;
  assign wr_last  = wr_fire && (waddr_q == AW'(DEPTH - 1));
  assign last_tap = (ch_q == CW'(CHIN - 1)) &&
                    (kx_q == KW'(KERNEL_DIM - 1)) &&
                    (ky_q == KW'(KERNEL_DIM - 1));
  assign last_win = (ox_q == OXW'(W_OUT - 1)) &&
                    (oy_q == OYW'(H_OUT - 1));
  // The whole pipeline moves unless a valid pixel is waiting on the consumer
  assign adv      = !pv_q || pix_ready;
  assign drained  = !(v1_q || wl1_q || pv_q || wl_q);

  assign ix = IW'(ox_q) * IW'(STRIDE) + IW'(kx_q) - IW'(PAD_E);
  assign iy = IW'(oy_q) * IW'(STRIDE) + IW'(ky_q) - IW'(PAD_E);
  assign addr_d = (AW'(iy) * AW'(W_IN) + AW'(ix)) * AW'(CHIN) + AW'(ch_q);

`ifdef FIRE5_EX_3_ZERO_PAD_EN
  logic pad_q, pad_d;
  // Negative coordinates wrap to large unsigned values, so one compare covers both edges
  assign pad_d = (ix >= IW'(W_IN)) || (iy >= IW'(H_IN));
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD:    if (wr_last) state_d = READY;
      READY:   if (start) state_d = STREAM;
      STREAM:  if (adv && last_tap) state_d = GAP;
      GAP:     if (adv) state_d = last_win ? DONE : STREAM;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_comb begin
    wr_ready = (state_q == LOAD);
    loaded   = (state_q != LOAD);
    busy     = (state_q == STREAM) || (state_q == GAP) ||
               ((state_q == DONE) && !drained);
    done     = (state_q == DONE) && drained;
  end

  assign pix       = pix_q;
  assign pix_valid = pv_q;
  assign win_last  = wl_q;

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[waddr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      ch_q    <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      if (wr_fire) waddr_q <= waddr_q + 1'b1;
      if (state_q == STREAM && adv) begin
        if (ch_q == CW'(CHIN - 1)) begin
          ch_q <= '0;
          if (kx_q == KW'(KERNEL_DIM - 1)) begin
            kx_q <= '0;
            if (ky_q == KW'(KERNEL_DIM - 1)) ky_q <= '0;
            else                            ky_q <= ky_q + 1'b1;
          end else begin
            kx_q <= kx_q + 1'b1;
          end
        end else begin
          ch_q <= ch_q + 1'b1;
        end
      end
      if (state_q == GAP && adv) begin
        if (ox_q == OXW'(W_OUT - 1)) begin
          ox_q <= '0;
          if (oy_q == OYW'(H_OUT - 1)) oy_q <= '0;
          else                        oy_q <= oy_q + 1'b1;
        end else begin
          ox_q <= ox_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      wl1_q  <= 1'b0;
      pv_q   <= 1'b0;
      wl_q   <= 1'b0;
      addr_q <= '0;
      pix_q  <= '0;
`ifdef FIRE5_EX_3_ZERO_PAD_EN
      pad_q  <= 1'b0;
`endif
    end else if (adv) begin
      v1_q   <= (state_q == STREAM);
      wl1_q  <= (state_q == GAP);
      addr_q <= addr_d;
      pv_q   <= v1_q;
      wl_q   <= wl1_q;
`ifdef FIRE5_EX_3_ZERO_PAD_EN
      pad_q  <= pad_d;
      pix_q  <= (v1_q && !pad_q) ? mem_q[addr_q] : '0;
`else
      pix_q  <= v1_q ? mem_q[addr_q] : '0;
`endif
    end
  end

endmodule
